// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is resolved per stage, carry registered between stages.
// Latency WIDTH/GROUP cycles, one result per cycle; the whole pipe holds while out_valid && !out_ready (in_ready = advance).
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             gg,
    output logic             pg
);
    localparam int L = WIDTH / GROUP;

    logic             advance;
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_cond   = sub ? ~b : b;
    assign c0       = sub ? ~cin : cin;

    for (genvar k = 0; k < L; k++) begin : g_stage
        // IW: operand bits still unresolved on entry; SW: sum bits resolved on exit
        localparam int IW = WIDTH - k * GROUP;
        localparam int SW = (k + 1) * GROUP;

        logic [IW-1:0]    a_in;
        logic [IW-1:0]    b_in;
        logic             v_in;
        logic             c_in;
        logic             gacc_in;
        logic             pacc_in;
        logic [GROUP-1:0] gb;
        logic [GROUP-1:0] pb;
        logic [GROUP-1:0] sg;
        logic [GROUP:1]   gl;
        logic [GROUP:0]   cb;
        logic             term;
        logic             grp_g;
        logic             grp_p;
        logic [SW-1:0]    s_d;
        logic [SW-1:0]    s_q;
        logic             v_q;
        logic             c_q;
        logic             g_q;
        logic             p_q;

        if (k == 0) begin : g_first
            assign a_in    = a;
            assign b_in    = b_cond;
            assign v_in    = in_valid;
            assign c_in    = c0;
            assign gacc_in = 1'b0;
            assign pacc_in = 1'b1;
            assign s_d     = sg;
        end else begin : g_next
            assign a_in    = g_stage[k-1].g_fwd.a_q;
            assign b_in    = g_stage[k-1].g_fwd.b_q;
            assign v_in    = g_stage[k-1].v_q;
            assign c_in    = g_stage[k-1].c_q;
            assign gacc_in = g_stage[k-1].g_q;
            assign pacc_in = g_stage[k-1].p_q;
            assign s_d     = {sg, g_stage[k-1].s_q};
        end

        // Sum-of-products lookahead: every carry is built directly from g/p and the group carry-in
        always_comb begin
            gb    = a_in[GROUP-1:0] & b_in[GROUP-1:0];
            pb    = a_in[GROUP-1:0] ^ b_in[GROUP-1:0];
            gl    = '0;
            cb    = '0;
            term  = 1'b0;
            cb[0] = c_in;
            for (int j = 0; j < GROUP; j++) begin
                for (int i = 0; i <= j; i++) begin
                    term = gb[i];
                    for (int m = i + 1; m <= j; m++) term = term & pb[m];
                    gl[j+1] = gl[j+1] | term;
                end
                term = c_in;
                for (int m = 0; m <= j; m++) term = term & pb[m];
                cb[j+1] = gl[j+1] | term;
            end
            grp_g = gl[GROUP];
            grp_p = &pb;
            sg    = pb ^ cb[GROUP-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
                g_q <= 1'b0;
                p_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
                s_q <= s_d;
                c_q <= cb[GROUP];
                g_q <= grp_g | (grp_p & gacc_in);
                p_q <= grp_p & pacc_in;
            end
        end

        if (k < L - 1) begin : g_fwd
            logic [IW-GROUP-1:0] a_q;
            logic [IW-GROUP-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IW-1:GROUP];
                    b_q <= b_in[IW-1:GROUP];
                end
            end
        end else begin : g_last
            // Carry into the MSB, needed only for the signed overflow flag
            logic m_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_q <= 1'b0;
                end else if (advance) begin
                    m_q <= cb[GROUP-1];
                end
            end
        end
    end

    assign out_valid = g_stage[L-1].v_q;
    assign sum       = g_stage[L-1].s_q;
    assign cout      = g_stage[L-1].c_q;
    assign ovf       = g_stage[L-1].c_q ^ g_stage[L-1].g_last.m_q;
    assign gg        = g_stage[L-1].g_q;
    assign pg        = g_stage[L-1].p_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: 16/4 directed + streaming + stall + reset cases,
// plus randomized traffic on 16/4, 32/8 and 12/3 against an arithmetic reference.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, gg, pg;
    logic [15:0] a, b, sum;

    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf, w_gg, w_pg;
    logic [31:0] w_a, w_b, w_sum;

    logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf, n_gg, n_pg;
    logic [11:0] n_a, n_b, n_sum;

    int nvec;
    int nerr;
    logic [35:0] expq[$];
    logic [35:0] wq[$];
    logic [35:0] nq[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .gg(gg), .pg(pg));

    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
        .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
        .cout(w_cout), .ovf(w_ovf), .gg(w_gg), .pg(w_pg));

    pipelined_cla_adder #(.WIDTH(12), .GROUP(3)) u_dut_n (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
        .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid), .out_ready(n_out_ready), .sum(n_sum),
        .cout(n_cout), .ovf(n_ovf), .gg(n_gg), .pg(n_pg));

    // Reference: plain integer arithmetic. Returns {pg, gg, ovf, cout, sum[31:0]}.
    function automatic logic [35:0] ref_model(input int w, input longint av, input longint bv,
                                              input logic ci, input logic sb);
        longint full, half, mask, sa, sbv, bp, c, raw, r, res;
        logic co, ov, g, p;
        full = 64'sd1 <<< w;
        half = 64'sd1 <<< (w - 1);
        mask = full - 1;
        c    = ci ? 64'sd1 : 64'sd0;
        sa   = (av >= half) ? av - full : av;
        sbv  = (bv >= half) ? bv - full : bv;
        bp   = sb ? (~bv & mask) : bv;
        if (sb) begin
            raw = av - bv - c;
            co  = (av >= bv + c);
            r   = sa - sbv - c;
        end else begin
            raw = av + bv + c;
            co  = (raw >= full);
            r   = sa + sbv + c;
        end
        ov  = (r >= half) || (r < -half);
        g   = ((av + bp) >= full);
        p   = ((av ^ bp) == mask);
        res = raw & mask;
        return {p, g, ov, co, res[31:0]};
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (out_valid !== 1'b0 || w_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_out_valid: got %b%b%b want 000", out_valid, w_out_valid, n_out_valid);
        end
        nvec++;
        if ({sum, cout, ovf, gg, pg} !== 20'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got sum=%h c/o/gg/pg=%b%b%b%b want all 0", sum, cout, ovf, gg, pg);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Directed vectors, each checked for exact latency: valid only after the 4th edge
    task automatic test_directed;
        logic [15:0] ta [6];
        logic [15:0] tb_ [6];
        logic [1:0]  tcs [6];
        logic [19:0] te [6];
        ta  = '{16'hFFFF, 16'h0005, 16'h0005, 16'h7FFF, 16'h8000, 16'hAAAA};
        tb_ = '{16'h0001, 16'h0007, 16'h0007, 16'h0001, 16'h0001, 16'h5555};
        tcs = '{2'b00,    2'b10,    2'b11,    2'b00,    2'b10,    2'b01};
        te  = '{20'h5_0000, 20'h0_FFFE, 20'h0_FFFD, 20'h2_8000, 20'h7_7FFF, 20'h9_0000};
        idle(6);
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = ta[v];
            b = tb_[v];
            sub = tcs[v][1];
            cin = tcs[v][0];
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int e = 0; e < 3; e++) begin
                nvec++;
                if (out_valid !== 1'b0) begin
                    nerr++;
                    $display("FAIL dir%0d_early_valid edge+%0d: got %b want 0", v, e, out_valid);
                end
                @(posedge clk);
                #1;
            end
            nvec++;
            if (out_valid !== 1'b1 || {pg, gg, ovf, cout, sum} !== te[v]) begin
                nerr++;
                $display("FAIL dir%0d_result: got v=%b %h want v=1 %h", v, out_valid,
                         {pg, gg, ovf, cout, sum}, te[v]);
            end
        end
    endtask

    task automatic test_streaming;
        logic [35:0] exp;
        expq.delete();
        idle(5);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = (c < 8);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            #1;
            if (in_valid) begin
                nvec++;
                if (in_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready);
                end
                expq.push_back(ref_model(16, a, b, cin, sub));
            end
            @(posedge clk);
            #1;
            nvec++;
            if (out_valid !== (c >= 3 && c <= 10)) begin
                nerr++;
                $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid, (c >= 3 && c <= 10));
            end
            if (out_valid && expq.size() > 0) begin
                exp = expq.pop_front();
                nvec++;
                if ({pg, gg, ovf, cout, 16'h0, sum} !== exp) begin
                    nerr++;
                    $display("FAIL stream_data c=%0d: got %h want %h", c, {pg, gg, ovf, cout, 16'h0, sum}, exp);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [35:0] exp, got, held;
        int n_out;
        n_out = 0;
        held = '0;
        expq.delete();
        idle(5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = (c < 9);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            out_ready = !(c >= 4 && c <= 6);
            #1;
            got = {pg, gg, ovf, cout, 16'h0, sum};
            if (c >= 4 && c <= 6) begin
                nvec++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL bp_stall c=%0d: got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
                end
                if (c == 4) held = got;
                else begin
                    nvec++;
                    if (got !== held) begin
                        nerr++;
                        $display("FAIL bp_hold c=%0d: got %h want %h", c, got, held);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL bp_extra: got result %h want none", got);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        nerr++;
                        $display("FAIL bp_data c=%0d: got %h want %h", c, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) expq.push_back(ref_model(16, a, b, cin, sub));
            @(posedge clk);
        end
        nvec++;
        if (n_out != 6 || expq.size() != 0) begin
            nerr++;
            $display("FAIL bp_count: got %0d results (%0d pending) want 6 (0)", n_out, expq.size());
        end
    endtask

    task automatic test_reset_midstream;
        int seen;
        idle(5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'hFFFF;
            b = 16'hFFFF - 16'(i);
            cin = 1'b0;
            sub = 1'b0;
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b1 || sum !== 16'hFFFE || cout !== 1'b1) begin
            nerr++;
            $display("FAIL rstm_prefill: got v=%b sum=%h c=%b want 1 fffe 1", out_valid, sum, cout);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || {sum, cout, ovf, gg, pg} !== 20'h0) begin
            nerr++;
            $display("FAIL rstm_clear: got v=%b sum=%h flags=%b%b%b%b want all 0", out_valid, sum, cout, ovf, gg, pg);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rstm_stale c=%0d: got out_valid=%b want 0", c, out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0F0F;
        sub = 1'b1;
        cin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = -1;
        for (int c = 0; c < 8 && seen < 0; c++) begin
            if (out_valid) seen = c;
            else begin
                @(posedge clk);
                #1;
            end
        end
        nvec++;
        if (seen != 3 || {pg, gg, ovf, cout, 16'h0, sum} !== ref_model(16, 16'h1234, 16'h0F0F, 1'b1, 1'b1)) begin
            nerr++;
            $display("FAIL rstm_restart: got at edge+%0d %h want edge+3 %h", seen,
                     {pg, gg, ovf, cout, 16'h0, sum}, ref_model(16, 16'h1234, 16'h0F0F, 1'b1, 1'b1));
        end
    endtask

    task automatic test_random;
        logic [35:0] exp, got, held;
        logic was_stall;
        expq.delete();
        idle(6);
        was_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
            in_valid = (c < 400) && ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? ~a : 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            got = {pg, gg, ovf, cout, 16'h0, sum};
            nvec++;
            if (in_ready !== (!out_valid || out_ready)) begin
                nerr++;
                $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, (!out_valid || out_ready));
            end
            if (was_stall) begin
                nvec++;
                if (out_valid !== 1'b1 || got !== held) begin
                    nerr++;
                    $display("FAIL rnd_hold c=%0d: got v=%b %h want v=1 %h", c, out_valid, got, held);
                end
            end
            was_stall = out_valid && !out_ready;
            held = got;
            if (out_valid && out_ready) begin
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL rnd_extra c=%0d: got %h want none", c, got);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        nerr++;
                        $display("FAIL rnd_data c=%0d: got %h want %h", c, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) expq.push_back(ref_model(16, a, b, cin, sub));
            @(posedge clk);
        end
        nvec++;
        if (expq.size() != 0) begin
            nerr++;
            $display("FAIL rnd_lost: got %0d results never emerged want 0", expq.size());
        end
    endtask

    // 32/8 and 12/3 instances, each with independent random traffic
    task automatic test_random_params;
        logic [35:0] exp, got;
        wq.delete();
        nq.delete();
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            w_out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
            w_in_valid = (c < 300) && ($urandom_range(0, 3) != 0);
            w_a = $urandom;
            w_b = ($urandom_range(0, 7) == 0) ? ~w_a : $urandom;
            w_cin = 1'($urandom_range(0, 1));
            w_sub = 1'($urandom_range(0, 1));
            n_out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
            n_in_valid = (c < 300) && ($urandom_range(0, 2) != 0);
            n_a = 12'($urandom);
            n_b = ($urandom_range(0, 7) == 0) ? ~n_a : 12'($urandom);
            n_cin = 1'($urandom_range(0, 1));
            n_sub = 1'($urandom_range(0, 1));
            #1;
            if (w_out_valid && w_out_ready) begin
                got = {w_pg, w_gg, w_ovf, w_cout, w_sum};
                nvec++;
                if (wq.size() == 0) begin
                    nerr++;
                    $display("FAIL w32_extra c=%0d: got %h want none", c, got);
                end else begin
                    exp = wq.pop_front();
                    if (got !== exp) begin
                        nerr++;
                        $display("FAIL w32_data c=%0d: got %h want %h", c, got, exp);
                    end
                end
            end
            if (n_out_valid && n_out_ready) begin
                got = {n_pg, n_gg, n_ovf, n_cout, 20'h0, n_sum};
                nvec++;
                if (nq.size() == 0) begin
                    nerr++;
                    $display("FAIL w12_extra c=%0d: got %h want none", c, got);
                end else begin
                    exp = nq.pop_front();
                    if (got !== exp) begin
                        nerr++;
                        $display("FAIL w12_data c=%0d: got %h want %h", c, got, exp);
                    end
                end
            end
            if (w_in_valid && w_in_ready) wq.push_back(ref_model(32, w_a, w_b, w_cin, w_sub));
            if (n_in_valid && n_in_ready) nq.push_back(ref_model(12, n_a, n_b, n_cin, n_sub));
            @(posedge clk);
        end
        nvec++;
        if (wq.size() != 0 || nq.size() != 0) begin
            nerr++;
            $display("FAIL param_lost: got %0d/%0d pending want 0/0", wq.size(), nq.size());
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        {in_valid, cin, sub, out_ready, a, b} = '0;
        {w_in_valid, w_cin, w_sub, w_out_ready, w_a, w_b} = '0;
        {n_in_valid, n_cin, n_sub, n_out_ready, n_a, n_b} = '0;
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_random();
        test_random_params();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
